// File: rtl/ebpc_pkg.sv
// Shared constants and types for the EBPC encoder front end.
//   DATA_W           : width of raw activations, znz words and nz words
//   MAX_ZRLE_LEN     : longest zero run a single ZRLE symbol can describe
//   LOG_MAX_ZRLE_LEN : width of the run-length field inside a run symbol
//   znz_state_e      : ZNZ encoder block state (ACCEPT inputs / DRAIN packer)
package ebpc_pkg;

  localparam int DATA_W           = 8;
  localparam int MAX_ZRLE_LEN     = 16;
  localparam int LOG_MAX_ZRLE_LEN = $clog2(MAX_ZRLE_LEN);

  typedef enum logic {
    ACCEPT = 1'b0,
    DRAIN  = 1'b1
  } znz_state_e;

endpackage

// File: rtl/ebpc_bit_packer.sv
// Variable-length bit packer: appends 0..SYM_W bits per cycle into a
// 2*DATA_W buffer and emits DATA_W-bit words, MSB first.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   add_vld       : append add_len bits this cycle
//   add_data      : symbol bits, right-aligned (bits above add_len must be 0)
//   add_len       : number of bits to append (0..SYM_W)
//   drain         : block is complete; flush remaining bits with zero padding
//   out_data      : top DATA_W bits of the buffer
//   out_vld       : out_data holds a word to send
//   out_last      : out_data is the final word of the block (only while draining)
//   out_rdy       : downstream accepts out_data
//   fill          : number of valid bits currently buffered
module ebpc_bit_packer #(
  parameter int DATA_W = 8,
  parameter int SYM_W  = 6,
  parameter int LEN_W  = $clog2(SYM_W + 1),
  parameter int FILL_W = $clog2(2 * DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              add_vld,
  input  logic [SYM_W-1:0]  add_data,
  input  logic [LEN_W-1:0]  add_len,
  input  logic              drain,
  output logic [DATA_W-1:0] out_data,
  output logic              out_vld,
  output logic              out_last,
  input  logic              out_rdy,
  output logic [FILL_W-1:0] fill
);

  localparam int BUF_W = 2 * DATA_W;
  localparam logic [FILL_W-1:0] FILL_WORD = FILL_W'(DATA_W);
  localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(SYM_W);

  // Valid bits are kept left-aligned: buf_q[BUF_W-1 -: fill_q]; everything
  // below is zero, so a partial final word is padded for free.
  logic [BUF_W-1:0]  buf_q, buf_d, buf_shift, sym_aligned;
  logic [FILL_W-1:0] fill_q, fill_d, fill_shift;
  logic              xfer;

  always_comb begin
    out_vld  = (fill_q >= FILL_WORD) | (drain & (fill_q != '0));
    out_last = drain & (fill_q <= FILL_WORD);
    out_data = buf_q[BUF_W-1 -: DATA_W];
    fill     = fill_q;
    xfer     = out_vld & out_rdy;

    // Shift out the sent word first, then append behind what remains.
    buf_shift  = xfer ? (buf_q << DATA_W) : buf_q;
    fill_shift = xfer ? (fill_q - FILL_WORD) : fill_q;

    // Left-align the symbol to the buffer MSB, dropping the unused top bits.
    sym_aligned = {add_data, {(BUF_W - SYM_W){1'b0}}} << (LEN_MAX - add_len);

    buf_d  = buf_shift;
    fill_d = fill_shift;
    if (add_vld) begin
      buf_d  = buf_shift | (sym_aligned >> fill_shift);
      fill_d = fill_shift + FILL_W'(add_len);
    end
    if (xfer && out_last) begin
      buf_d  = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/ebpc_znz_encoder.sv
// ZNZ encoder: splits a block of activations into a zero/non-zero mask,
// run-length encodes the mask (ZRLE) into packed DATA_W-bit znz words and
// forwards the non-zero values on the nz stream.
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   data_i/last_i        : raw word and end-of-block marker
//   vld_i/rdy_o          : input handshake
//   znz_o/znz_last_o     : packed ZRLE word (first symbol bit at MSB), block end
//   znz_vld_o/znz_rdy_i  : znz handshake
//   nz_o                 : non-zero word
//   nz_vld_o/nz_rdy_i    : nz handshake
//   state_o              : current block state, for observation
//
// Handshakes (all three ports): a word moves on a rising edge where valid and
// ready are both high; a source holds valid high and data stable until that
// edge. Symbols: non-zero word -> "1"; zero run of n -> "0" + (n-1) in
// LOG_MAX_ZRLE_LEN bits, MSB first.
module ebpc_znz_encoder
  import ebpc_pkg::*;
#(
  parameter int DATA_W           = ebpc_pkg::DATA_W,
  parameter int MAX_ZRLE_LEN     = ebpc_pkg::MAX_ZRLE_LEN,
  parameter int LOG_MAX_ZRLE_LEN = ebpc_pkg::LOG_MAX_ZRLE_LEN
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              vld_i,
  output logic              rdy_o,
  output logic [DATA_W-1:0] znz_o,
  output logic              znz_vld_o,
  input  logic              znz_rdy_i,
  output logic              znz_last_o,
  output logic [DATA_W-1:0] nz_o,
  output logic              nz_vld_o,
  input  logic              nz_rdy_i,
  output znz_state_e        state_o
);

  localparam int SYM_W  = LOG_MAX_ZRLE_LEN + 2;
  localparam int LEN_W  = $clog2(SYM_W + 1);
  localparam int FILL_W = $clog2(2 * DATA_W + 1);
  localparam logic [LOG_MAX_ZRLE_LEN-1:0] RUN_ONE = LOG_MAX_ZRLE_LEN'(1);
  localparam logic [LOG_MAX_ZRLE_LEN:0]   RUN_MAX = MAX_ZRLE_LEN[LOG_MAX_ZRLE_LEN:0];

  znz_state_e                  state_q;
  // run_q counts zeros seen since the last emitted symbol (0 = nothing pending).
  logic [LOG_MAX_ZRLE_LEN-1:0] run_q, run_d;
  logic [LOG_MAX_ZRLE_LEN:0]   run_inc;
  logic [DATA_W-1:0]           nz_q;
  logic                        nz_vld_q;
  logic                        is_zero, accept;
  logic                        sym_vld;
  logic [SYM_W-1:0]            sym_data;
  logic [LEN_W-1:0]            sym_len;
  logic [DATA_W-1:0]           pk_data;
  logic                        pk_vld, pk_last;
  logic [FILL_W-1:0]           pk_fill;

  always_comb begin
    is_zero = (data_i == '0);
    // Packer holds < DATA_W bits when accepting; one input adds at most SYM_W
    // bits, so the 2*DATA_W buffer cannot overflow.
    rdy_o   = rst_ni & (state_q == ACCEPT) & (pk_fill < FILL_W'(DATA_W))
            & (!nz_vld_q | nz_rdy_i);
    accept  = vld_i & rdy_o;
    run_inc = {1'b0, run_q} + {{LOG_MAX_ZRLE_LEN{1'b0}}, 1'b1};

    sym_vld  = 1'b0;
    sym_data = '0;
    sym_len  = '0;
    run_d    = run_q;
    if (accept) begin
      if (is_zero) begin
        if ((run_inc == RUN_MAX) || last_i) begin
          // Run length n = run_q + 1, so the encoded field (n-1) is run_q.
          sym_vld  = 1'b1;
          sym_data = {2'b00, run_q};
          sym_len  = LEN_W'(SYM_W - 1);
          run_d    = '0;
        end else begin
          run_d = run_inc[LOG_MAX_ZRLE_LEN-1:0];
        end
      end else begin
        sym_vld = 1'b1;
        run_d   = '0;
        if (run_q != '0) begin
          sym_data = {1'b0, run_q - RUN_ONE, 1'b1};
          sym_len  = LEN_W'(SYM_W);
        end else begin
          sym_data = SYM_W'(1);
          sym_len  = LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ACCEPT;
      run_q    <= '0;
      nz_q     <= '0;
      nz_vld_q <= 1'b0;
    end else begin
      run_q <= run_d;
      case (state_q)
        ACCEPT: if (accept && last_i) state_q <= DRAIN;
        DRAIN:  if (pk_vld && pk_last && znz_rdy_i) state_q <= ACCEPT;
        default: state_q <= ACCEPT;
      endcase
      // Single-entry nz register; reload and consume may share a cycle.
      if (accept && !is_zero) begin
        nz_q     <= data_i;
        nz_vld_q <= 1'b1;
      end else if (nz_rdy_i) begin
        nz_vld_q <= 1'b0;
      end
    end
  end

  ebpc_bit_packer #(
    .DATA_W (DATA_W),
    .SYM_W  (SYM_W),
    .LEN_W  (LEN_W),
    .FILL_W (FILL_W)
  ) u_packer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .add_vld  (sym_vld),
    .add_data (sym_data),
    .add_len  (sym_len),
    .drain    (state_q == DRAIN),
    .out_data (pk_data),
    .out_vld  (pk_vld),
    .out_last (pk_last),
    .out_rdy  (znz_rdy_i),
    .fill     (pk_fill)
  );

  assign znz_o      = pk_data;
  assign znz_vld_o  = rst_ni & pk_vld;
  assign znz_last_o = rst_ni & pk_vld & pk_last;
  assign nz_o       = nz_q;
  assign nz_vld_o   = rst_ni & nz_vld_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_ebpc_znz_encoder.sv
// Directed bench for ebpc_znz_encoder: fixed blocks with hand-computed znz/nz
// words, backpressure and random stalls checked against a bit-level model.
module tb_ebpc_znz_encoder;
  import ebpc_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] data_i = '0;
  logic       last_i = 1'b0;
  logic       vld_i = 1'b0;
  logic       rdy_o;
  logic [7:0] znz_o;
  logic       znz_vld_o;
  logic       znz_rdy_i = 1'b1;
  logic       znz_last_o;
  logic [7:0] nz_o;
  logic       nz_vld_o;
  logic       nz_rdy_i = 1'b1;
  znz_state_e state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int znz_mode = 0;  // 0 always ready, 1 random stalls, 2 held low
  int nz_mode  = 0;  // 0 always ready, 1 random stalls
  bit drv_to   = 1'b0;

  logic [8:0] exp_znz_q[$];  // {last, data}
  logic [8:0] got_znz[$];
  logic [7:0] exp_nz_q[$];
  logic [7:0] got_nz[$];
  logic [7:0] blk_q[$];

  ebpc_znz_encoder dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .data_i     (data_i),
    .last_i     (last_i),
    .vld_i      (vld_i),
    .rdy_o      (rdy_o),
    .znz_o      (znz_o),
    .znz_vld_o  (znz_vld_o),
    .znz_rdy_i  (znz_rdy_i),
    .znz_last_o (znz_last_o),
    .nz_o       (nz_o),
    .nz_vld_o   (nz_vld_o),
    .nz_rdy_i   (nz_rdy_i),
    .state_o    (state_o)
  );

  // ---------------- clock / output-side ready drivers ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    int zc;
    int nc;
    zc = 0;
    nc = 0;
    forever begin
      @(posedge clk_i);
      #1;
      case (znz_mode)
        0: znz_rdy_i = 1'b1;
        2: znz_rdy_i = 1'b0;
        default: begin
          if (zc > 0) begin znz_rdy_i = 1'b0; zc--; end
          else begin znz_rdy_i = 1'b1; zc = $urandom_range(0, 3); end
        end
      endcase
      if (nz_mode == 0) nz_rdy_i = 1'b1;
      else if (nc > 0) begin nz_rdy_i = 1'b0; nc--; end
      else begin nz_rdy_i = 1'b1; nc = $urandom_range(0, 3); end
    end
  end

  // Inputs only change at posedge+1, so a handshake seen at negedge is the
  // one that completes on the next rising edge.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (znz_vld_o && znz_rdy_i) got_znz.push_back({znz_last_o, znz_o});
      if (nz_vld_o && nz_rdy_i) got_nz.push_back(nz_o);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [7:0] d, input logic l, input int gap);
    int g;
    int t;
    g = $urandom_range(0, gap);
    repeat (g) begin @(posedge clk_i); #1; end
    data_i = d;
    last_i = l;
    vld_i  = 1'b1;
    t = 0;
    forever begin
      @(negedge clk_i);
      if (rdy_o === 1'b1) break;
      t++;
      if (t > 2000) begin drv_to = 1'b1; break; end
    end
    @(posedge clk_i);
    #1;
    vld_i  = 1'b0;
    last_i = 1'b0;
    data_i = '0;
  endtask

  task automatic send_block(input int gap);
    for (int i = 0; i < blk_q.size(); i++)
      send_word(blk_q[i], (i == blk_q.size() - 1), gap);
  endtask

  // Reference encoder: build the symbol bit string, then cut into bytes.
  task automatic model_block();
    bit bq[$];
    int run;
    bit l;
    logic [7:0] w;
    run = 0;
    for (int i = 0; i < blk_q.size(); i++) begin
      l = (i == blk_q.size() - 1);
      if (blk_q[i] == 8'h00) begin
        run++;
        if (run == 16 || l) begin
          bq.push_back(1'b0);
          for (int b = 3; b >= 0; b--) bq.push_back((((run - 1) >> b) % 2) == 1);
          run = 0;
        end
      end else begin
        if (run > 0) begin
          bq.push_back(1'b0);
          for (int b = 3; b >= 0; b--) bq.push_back((((run - 1) >> b) % 2) == 1);
        end
        bq.push_back(1'b1);
        run = 0;
        exp_nz_q.push_back(blk_q[i]);
      end
    end
    while (bq.size() > 0) begin
      w = '0;
      for (int k = 7; k >= 0; k--) if (bq.size() > 0) w[k] = bq.pop_front();
      l = (bq.size() == 0);
      exp_znz_q.push_back({l, w});
    end
  endtask

  task automatic clear_q();
    exp_znz_q.delete();
    got_znz.delete();
    exp_nz_q.delete();
    got_nz.delete();
    blk_q.delete();
    drv_to = 1'b0;
  endtask

  // Wait (bounded) until all expected words arrived and the block closed,
  // then idle a little so any surplus output is also collected.
  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk_i);
      if (got_znz.size() >= exp_znz_q.size() && got_nz.size() >= exp_nz_q.size()
          && state_o == ACCEPT && !vld_i) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (10) @(negedge clk_i);
    if (drv_to) ok = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++; if (rdy_o !== 1'b0) begin n_fail++; $display("FAIL reset rdy_o: got %b want 0", rdy_o); end
    n_checks++; if (znz_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset znz_vld_o: got %b want 0", znz_vld_o); end
    n_checks++; if (znz_last_o !== 1'b0) begin n_fail++; $display("FAIL reset znz_last_o: got %b want 0", znz_last_o); end
    n_checks++; if (nz_vld_o !== 1'b0) begin n_fail++; $display("FAIL reset nz_vld_o: got %b want 0", nz_vld_o); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    n_checks++; if (rdy_o !== 1'b1) begin n_fail++; $display("FAIL post_reset rdy_o: got %b want 1", rdy_o); end
    n_checks++; if (state_o !== ACCEPT) begin n_fail++; $display("FAIL post_reset state: got %0d want ACCEPT", state_o); end
  endtask

  task automatic test_all_nonzero();
    bit ok;
    clear_q();
    for (int i = 1; i <= 8; i++) begin
      blk_q.push_back(8'(i));
      exp_nz_q.push_back(8'(i));
    end
    exp_znz_q.push_back({1'b1, 8'hFF});
    @(posedge clk_i); #1;
    send_block(0);
    wait_out(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL nonzero timeout: znz %0d/%0d nz %0d/%0d", got_znz.size(), exp_znz_q.size(), got_nz.size(), exp_nz_q.size()); end
    n_checks++; if (got_znz.size() != exp_znz_q.size()) begin n_fail++; $display("FAIL nonzero znz count: got %0d want %0d", got_znz.size(), exp_znz_q.size()); end
    for (int i = 0; i < exp_znz_q.size() && i < got_znz.size(); i++) begin
      n_checks++; if (got_znz[i] !== exp_znz_q[i]) begin n_fail++; $display("FAIL nonzero znz[%0d]: got %h want %h", i, got_znz[i], exp_znz_q[i]); end
    end
    n_checks++; if (got_nz.size() != exp_nz_q.size()) begin n_fail++; $display("FAIL nonzero nz count: got %0d want %0d", got_nz.size(), exp_nz_q.size()); end
    for (int i = 0; i < exp_nz_q.size() && i < got_nz.size(); i++) begin
      n_checks++; if (got_nz[i] !== exp_nz_q[i]) begin n_fail++; $display("FAIL nonzero nz[%0d]: got %h want %h", i, got_nz[i], exp_nz_q[i]); end
    end
  endtask

  task automatic test_short_run();
    bit ok;
    clear_q();
    blk_q = '{8'h00, 8'h00, 8'h05};
    exp_znz_q.push_back({1'b1, 8'h0C});  // 0 0001 1 + pad
    exp_nz_q.push_back(8'h05);
    @(posedge clk_i); #1;
    send_block(0);
    wait_out(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL short_run timeout: znz %0d/%0d nz %0d/%0d", got_znz.size(), exp_znz_q.size(), got_nz.size(), exp_nz_q.size()); end
    n_checks++; if (got_znz.size() != 1) begin n_fail++; $display("FAIL short_run znz count: got %0d want 1", got_znz.size()); end
    if (got_znz.size() > 0) begin
      n_checks++; if (got_znz[0] !== exp_znz_q[0]) begin n_fail++; $display("FAIL short_run znz: got %h want %h", got_znz[0], exp_znz_q[0]); end
    end
    n_checks++; if (got_nz.size() != 1) begin n_fail++; $display("FAIL short_run nz count: got %0d want 1", got_nz.size()); end
    if (got_nz.size() > 0) begin
      n_checks++; if (got_nz[0] !== exp_nz_q[0]) begin n_fail++; $display("FAIL short_run nz: got %h want %h", got_nz[0], exp_nz_q[0]); end
    end
  endtask

  task automatic test_full_run();
    bit ok;
    clear_q();
    for (int i = 0; i < 16; i++) blk_q.push_back(8'h00);
    exp_znz_q.push_back({1'b1, 8'h78});  // 0 1111 + pad
    @(posedge clk_i); #1;
    send_block(0);
    wait_out(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL full_run timeout: znz %0d/%0d", got_znz.size(), exp_znz_q.size()); end
    n_checks++; if (got_znz.size() != 1) begin n_fail++; $display("FAIL full_run znz count: got %0d want 1", got_znz.size()); end
    if (got_znz.size() > 0) begin
      n_checks++; if (got_znz[0] !== exp_znz_q[0]) begin n_fail++; $display("FAIL full_run znz: got %h want %h", got_znz[0], exp_znz_q[0]); end
    end
    n_checks++; if (got_nz.size() != 0) begin n_fail++; $display("FAIL full_run nz count: got %0d want 0", got_nz.size()); end
  endtask

  task automatic test_run_overflow();
    bit ok;
    clear_q();
    for (int i = 0; i < 17; i++) blk_q.push_back(8'h00);
    exp_znz_q.push_back({1'b0, 8'h78});  // 0 1111 | 0 0000 -> 0111_1000 00+pad
    exp_znz_q.push_back({1'b1, 8'h00});
    @(posedge clk_i); #1;
    send_block(0);
    wait_out(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL overflow timeout: znz %0d/%0d", got_znz.size(), exp_znz_q.size()); end
    n_checks++; if (got_znz.size() != exp_znz_q.size()) begin n_fail++; $display("FAIL overflow znz count: got %0d want %0d", got_znz.size(), exp_znz_q.size()); end
    for (int i = 0; i < exp_znz_q.size() && i < got_znz.size(); i++) begin
      n_checks++; if (got_znz[i] !== exp_znz_q[i]) begin n_fail++; $display("FAIL overflow znz[%0d]: got %h want %h", i, got_znz[i], exp_znz_q[i]); end
    end
    n_checks++; if (got_nz.size() != 0) begin n_fail++; $display("FAIL overflow nz count: got %0d want 0", got_nz.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    clear_q();
    blk_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
              8'h00, 8'h00, 8'h00, 8'h09, 8'h00, 8'h0A, 8'h0B, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h0D, 8'h00};
    model_block();
    znz_mode = 2;
    nz_mode  = 0;
    @(posedge clk_i); #1;
    fork
      send_block(0);
      begin
        for (int c = 0; c < 20; c++) begin
          @(negedge clk_i);
          if (c >= 12) begin
            n_checks++;
            if (rdy_o !== 1'b0 || znz_vld_o !== 1'b1) begin
              n_fail++;
              $display("FAIL backpressure hold c=%0d: rdy_o %b znz_vld_o %b want 0 1", c, rdy_o, znz_vld_o);
            end
          end
        end
        znz_mode = 1;
        nz_mode  = 1;
      end
    join
    wait_out(ok);
    znz_mode = 0;
    nz_mode  = 0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL backpressure timeout: znz %0d/%0d nz %0d/%0d", got_znz.size(), exp_znz_q.size(), got_nz.size(), exp_nz_q.size()); end
    n_checks++; if (got_znz.size() != exp_znz_q.size()) begin n_fail++; $display("FAIL backpressure znz count: got %0d want %0d", got_znz.size(), exp_znz_q.size()); end
    for (int i = 0; i < exp_znz_q.size() && i < got_znz.size(); i++) begin
      n_checks++; if (got_znz[i] !== exp_znz_q[i]) begin n_fail++; $display("FAIL backpressure znz[%0d]: got %h want %h", i, got_znz[i], exp_znz_q[i]); end
    end
    n_checks++; if (got_nz.size() != exp_nz_q.size()) begin n_fail++; $display("FAIL backpressure nz count: got %0d want %0d", got_nz.size(), exp_nz_q.size()); end
    for (int i = 0; i < exp_nz_q.size() && i < got_nz.size(); i++) begin
      n_checks++; if (got_nz[i] !== exp_nz_q[i]) begin n_fail++; $display("FAIL backpressure nz[%0d]: got %h want %h", i, got_nz[i], exp_nz_q[i]); end
    end
  endtask

  // Three blocks sent back to back with random stalls on every port.
  task automatic test_back_to_back();
    bit ok;
    int len;
    clear_q();
    znz_mode = 1;
    nz_mode  = 1;
    @(posedge clk_i); #1;
    for (int k = 0; k < 3; k++) begin
      blk_q.delete();
      len = $urandom_range(10, 30);
      for (int i = 0; i < len; i++) begin
        if (k == 1 && i >= 2 && i < 22) blk_q.push_back(8'h00);
        else if ($urandom_range(0, 3) < 2) blk_q.push_back(8'h00);
        else blk_q.push_back(8'($urandom_range(1, 255)));
      end
      model_block();
      send_block(3);
    end
    wait_out(ok);
    znz_mode = 0;
    nz_mode  = 0;
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b timeout: znz %0d/%0d nz %0d/%0d", got_znz.size(), exp_znz_q.size(), got_nz.size(), exp_nz_q.size()); end
    n_checks++; if (got_znz.size() != exp_znz_q.size()) begin n_fail++; $display("FAIL b2b znz count: got %0d want %0d", got_znz.size(), exp_znz_q.size()); end
    for (int i = 0; i < exp_znz_q.size() && i < got_znz.size(); i++) begin
      n_checks++; if (got_znz[i] !== exp_znz_q[i]) begin n_fail++; $display("FAIL b2b znz[%0d]: got %h want %h", i, got_znz[i], exp_znz_q[i]); end
    end
    n_checks++; if (got_nz.size() != exp_nz_q.size()) begin n_fail++; $display("FAIL b2b nz count: got %0d want %0d", got_nz.size(), exp_nz_q.size()); end
    for (int i = 0; i < exp_nz_q.size() && i < got_nz.size(); i++) begin
      n_checks++; if (got_nz[i] !== exp_nz_q[i]) begin n_fail++; $display("FAIL b2b nz[%0d]: got %h want %h", i, got_nz[i], exp_nz_q[i]); end
    end
  endtask

  task automatic test_reset_mid_block();
    bit ok;
    clear_q();
    @(posedge clk_i); #1;
    send_word(8'h00, 1'b0, 0);
    send_word(8'h03, 1'b0, 0);
    send_word(8'h00, 1'b0, 0);
    rst_ni = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      n_checks++;
      if (znz_vld_o !== 1'b0 || nz_vld_o !== 1'b0 || rdy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset outputs: znz_vld %b nz_vld %b rdy %b want 0 0 0", znz_vld_o, nz_vld_o, rdy_o);
      end
      @(posedge clk_i); #1;
    end
    rst_ni = 1'b1;
    clear_q();
    blk_q = '{8'h00, 8'h07};
    exp_znz_q.push_back({1'b1, 8'h04});  // 0 0000 1 + pad, nothing carried over
    exp_nz_q.push_back(8'h07);
    send_block(0);
    wait_out(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_reset timeout: znz %0d/%0d nz %0d/%0d", got_znz.size(), exp_znz_q.size(), got_nz.size(), exp_nz_q.size()); end
    n_checks++; if (got_znz.size() != 1) begin n_fail++; $display("FAIL mid_reset znz count: got %0d want 1", got_znz.size()); end
    if (got_znz.size() > 0) begin
      n_checks++; if (got_znz[0] !== exp_znz_q[0]) begin n_fail++; $display("FAIL mid_reset znz: got %h want %h", got_znz[0], exp_znz_q[0]); end
    end
    n_checks++; if (got_nz.size() != 1) begin n_fail++; $display("FAIL mid_reset nz count: got %0d want 1", got_nz.size()); end
    if (got_nz.size() > 0) begin
      n_checks++; if (got_nz[0] !== exp_nz_q[0]) begin n_fail++; $display("FAIL mid_reset nz: got %h want %h", got_nz[0], exp_nz_q[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_all_nonzero();
    test_short_run();
    test_full_run();
    test_run_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_block();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
